// File: rtl/dii_packet_buffer.sv
// Flit buffer for DII packets: circular {last, data} storage with an optional
// store-and-forward mode that only releases complete packets.
module dii_packet_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int FULLPACKET = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic                         in_last,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic                         out_last,
   output logic [DATA_WIDTH-1:0]        out_data,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic [$clog2(DEPTH+1)-1:0]   packet_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DATA_WIDTH:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;

   assign full     = (level == CW'(DEPTH));
   assign empty    = (level == '0);
   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;

   assign out_last = mem[rd_ptr][DATA_WIDTH];
   assign out_data = mem[rd_ptr][DATA_WIDTH-1:0];

   // In packet mode a full buffer must still drain, otherwise a packet longer
   // than the buffer would never see its last flit arrive.
   always_comb begin
      out_valid = !empty;
      if (FULLPACKET != 0)
         out_valid = !empty && ((packet_count != '0) || full);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {in_last, in_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         packet_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);

         case ({push, pop})
            2'b10:   level <= level + CW'(1);
            2'b01:   level <= level - CW'(1);
            default: level <= level;
         endcase

         case ({push && in_last, pop && out_last})
            2'b10:   packet_count <= packet_count + CW'(1);
            2'b01:   packet_count <= packet_count - CW'(1);
            default: packet_count <= packet_count;
         endcase
      end
   end

endmodule

// File: tb/tb_dii_packet_buffer.sv
// Bench for dii_packet_buffer: three configurations share one stimulus bus;
// sel picks whose outputs are checked and scoreboarded.
module tb_dii_packet_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_last;
   logic [15:0] in_data;
   logic        out_ready;

   logic        ir0, ov0, ol0, ir1, ov1, ol1, ir2, ov2, ol2;
   logic [15:0] od0, od1, od2;
   logic [3:0]  lv0, pc0, lv1, pc1;
   logic [2:0]  lv2, pc2;

   logic [1:0]  sel;
   logic        cur_in_ready, cur_out_valid, cur_out_last;
   logic [15:0] cur_out_data;
   logic [3:0]  cur_level, cur_pc;

   logic [16:0] sb [$];
   logic        accepted;
   int          popped;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      logic        iv;
      logic        il;
      logic [15:0] d;
      logic        ordy;
      logic [3:0]  lv;
      logic [3:0]  pc;
      logic        ir;
      logic        ov;
   } vec_t;
   vec_t vecs [$];

   always #5 clk = ~clk;

   dii_packet_buffer #(.DATA_WIDTH(16), .DEPTH(8), .FULLPACKET(0)) u_stream (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
      .in_ready(ir0), .out_valid(ov0), .out_last(ol0), .out_data(od0),
      .out_ready(out_ready), .level(lv0), .packet_count(pc0));

   dii_packet_buffer #(.DATA_WIDTH(16), .DEPTH(8), .FULLPACKET(1)) u_pkt8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
      .in_ready(ir1), .out_valid(ov1), .out_last(ol1), .out_data(od1),
      .out_ready(out_ready), .level(lv1), .packet_count(pc1));

   dii_packet_buffer #(.DATA_WIDTH(16), .DEPTH(4), .FULLPACKET(1)) u_pkt4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
      .in_ready(ir2), .out_valid(ov2), .out_last(ol2), .out_data(od2),
      .out_ready(out_ready), .level(lv2), .packet_count(pc2));

   always_comb begin
      cur_in_ready  = ir0;
      cur_out_valid = ov0;
      cur_out_last  = ol0;
      cur_out_data  = od0;
      cur_level     = lv0;
      cur_pc        = pc0;
      if (sel == 2'd1) begin
         cur_in_ready  = ir1;
         cur_out_valid = ov1;
         cur_out_last  = ol1;
         cur_out_data  = od1;
         cur_level     = lv1;
         cur_pc        = pc1;
      end else if (sel == 2'd2) begin
         cur_in_ready  = ir2;
         cur_out_valid = ov2;
         cur_out_last  = ol2;
         cur_out_data  = od2;
         cur_level     = {1'b0, lv2};
         cur_pc        = {1'b0, pc2};
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic checkState(input string tag, input logic [3:0] lv, input logic [3:0] pc,
                             input logic ir, input logic ov);
      checkOutput({tag, "_level"}, 32'(cur_level), 32'(lv));
      checkOutput({tag, "_pcount"}, 32'(cur_pc), 32'(pc));
      checkOutput({tag, "_in_ready"}, 32'(cur_in_ready), 32'(ir));
      checkOutput({tag, "_out_valid"}, 32'(cur_out_valid), 32'(ov));
   endtask

   // One cycle: drive, score any pop/push about to happen, then step past the edge.
   task automatic applyStimulus(input logic iv, input logic il, input logic [15:0] d, input logic ordy);
      logic [16:0] exp;
      in_valid  = iv;
      in_last   = il;
      in_data   = d;
      out_ready = ordy;
      #1;
      accepted = iv && cur_in_ready;
      if (cur_out_valid && ordy) begin
         if (sb.size() == 0) begin
            checkOutput("pop_unexpected", 32'(1), 32'(0));
         end else begin
            exp = sb.pop_front();
            checkOutput("pop_flit", 32'({cur_out_last, cur_out_data}), 32'(exp));
            popped++;
         end
      end
      if (accepted)
         sb.push_back({il, d});
      @(posedge clk);
      #1;
   endtask

   // Reset wins over a simultaneous push and pop.
   task automatic doReset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_last   = 1'b1;
      in_data   = 16'hdead;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      sb.delete();
      popped = 0;
   endtask

   function automatic vec_t mk(input logic iv, input logic il, input logic [15:0] d, input logic ordy,
                               input logic [3:0] lv, input logic [3:0] pc, input logic ir, input logic ov);
      vec_t v;
      v.iv = iv; v.il = il; v.d = d; v.ordy = ordy;
      v.lv = lv; v.pc = pc; v.ir = ir; v.ov = ov;
      return v;
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      sel       = 2'd0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      popped    = 0;

      // Streaming two-flit packet, then overfill with out_ready low and drain.
      vecs.push_back(mk(1, 0, 16'h1111, 1, 4'd1, 4'd0, 1, 1));
      vecs.push_back(mk(1, 1, 16'h2222, 1, 4'd1, 4'd1, 1, 1));
      vecs.push_back(mk(0, 0, 16'h0000, 1, 4'd0, 4'd0, 1, 0));
      for (int k = 1; k <= 9; k++)
         vecs.push_back(mk(1, 0, 16'h3000 + 16'(k), 0, (k <= 8) ? 4'(k) : 4'd8, 4'd0, k < 8, 1));
      for (int k = 7; k >= 0; k--)
         vecs.push_back(mk(0, 0, 16'h0000, 1, 4'(k), 4'd0, 1, k != 0));

      doReset();
      checkState("reset", 4'd0, 4'd0, 1, 0);
      foreach (vecs[i])  begin
         applyStimulus(vecs[i].iv, vecs[i].il, vecs[i].d, vecs[i].ordy);
         checkState($sformatf("vec%0d", i), vecs[i].lv, vecs[i].pc, vecs[i].ir, vecs[i].ov);
      end
      checkOutput("stream_popped", 32'(popped), 32'd10);
      checkOutput("stream_sb_empty", 32'(sb.size()), 32'd0);

      // Hold level at 4 while the write pointer wraps 7->0.
      doReset();
      for (int k = 1; k <= 4; k++)
         applyStimulus(1, 0, 16'h4000 + 16'(k), 0);
      checkState("wrap_fill", 4'd4, 4'd0, 1, 1);
      for (int k = 5; k <= 10; k++) begin
         applyStimulus(1, k == 10, 16'h4000 + 16'(k), 1);
         checkOutput("wrap_level", 32'(cur_level), 32'd4);
      end
      for (int k = 0; k < 4; k++)
         applyStimulus(0, 0, 16'h0000, 1);
      checkState("wrap_drain", 4'd0, 4'd0, 1, 0);
      checkOutput("wrap_popped", 32'(popped), 32'd10);

      // Reset mid-traffic discards everything; a fresh flit comes out, not stale data.
      doReset();
      for (int k = 1; k <= 5; k++)
         applyStimulus(1, (k == 2) || (k == 4), 16'h6000 + 16'(k), 0);
      checkState("prereset", 4'd5, 4'd2, 1, 1);
      doReset();
      checkState("midreset", 4'd0, 4'd0, 1, 0);
      applyStimulus(1, 1, 16'h7777, 0);
      checkState("postreset_push", 4'd1, 4'd1, 1, 1);
      applyStimulus(0, 0, 16'h0000, 1);
      checkState("postreset_pop", 4'd0, 4'd0, 1, 0);
      checkOutput("postreset_popped", 32'(popped), 32'd1);

      // Packet mode, depth 8: nothing leaves until the last flit is stored.
      sel = 2'd1;
      doReset();
      checkState("pkt8_reset", 4'd0, 4'd0, 1, 0);
      applyStimulus(1, 0, 16'haaa1, 1);
      checkState("pkt8_p1", 4'd1, 4'd0, 1, 0);
      applyStimulus(1, 0, 16'haaa2, 1);
      checkState("pkt8_p2", 4'd2, 4'd0, 1, 0);
      applyStimulus(1, 1, 16'haaa3, 1);
      checkState("pkt8_p3", 4'd3, 4'd1, 1, 1);
      applyStimulus(0, 0, 16'h0000, 1);
      checkState("pkt8_d1", 4'd2, 4'd1, 1, 1);
      applyStimulus(0, 0, 16'h0000, 1);
      checkState("pkt8_d2", 4'd1, 4'd1, 1, 1);
      applyStimulus(0, 0, 16'h0000, 1);
      checkState("pkt8_d3", 4'd0, 4'd0, 1, 0);
      checkOutput("pkt8_popped", 32'(popped), 32'd3);

      // Packet mode, depth 4: an oversize packet streams out via the full escape.
      sel = 2'd2;
      doReset();
      for (int k = 1; k <= 6; k++) begin
         int tries;
         tries = 0;
         accepted = 1'b0;
         while (!accepted && tries < 10) begin
            applyStimulus(1, k == 6, 16'h5000 + 16'(k), 1);
            tries++;
         end
         if (!accepted)
            checkOutput("pkt4_accept", 32'(0), 32'(1));
         if (k <= 3)
            checkState($sformatf("pkt4_p%0d", k), 4'(k), 4'd0, 1, 0);
         else if (k == 4)
            checkState("pkt4_full", 4'd4, 4'd0, 0, 1);
      end
      for (int t = 0; t < 20 && cur_level != 4'd0; t++)
         applyStimulus(0, 0, 16'h0000, 1);
      checkState("pkt4_drain", 4'd0, 4'd0, 1, 0);
      checkOutput("pkt4_popped", 32'(popped), 32'd6);
      checkOutput("pkt4_sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dii_packet_buffer.md
DII_PACKET_BUFFER -- requirements
Module: dii_packet_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: flit payload width in bits; legal values are 1 or more.
REQ-002 SHALL have parameter DEPTH, default 8: number of flit entries; a power of two, 2 or more.
REQ-003 SHALL have parameter FULLPACKET, default 0: 0 = forward flit-by-flit, 1 = forward only complete packets.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream flit valid.
REQ-007 SHALL have port in_last, input, 1 bit: upstream flit is the final flit of its packet.
REQ-008 SHALL have port in_data, input, DATA_WIDTH bits: upstream flit payload.
REQ-009 SHALL have port in_ready, output, 1 bit: the buffer can accept a flit this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit: downstream flit valid.
REQ-011 SHALL have port out_last, output, 1 bit: downstream flit is the final flit of its packet.
REQ-012 SHALL have port out_data, output, DATA_WIDTH bits: downstream flit payload.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the flit.
REQ-014 SHALL have port level, output, $clog2(DEPTH+1) bits: number of stored flits.
REQ-015 SHALL have port packet_count, output, $clog2(DEPTH+1) bits: number of stored flits with last=1.

Function
REQ-016 SHALL store {last, data} in a circular array of DEPTH entries, addressed by write and read pointers that wrap from DEPTH-1 to 0.
REQ-017 SHALL accept a flit (push) on a cycle with in_valid && in_ready; in_ready = (level != DEPTH), combinational from registered state only.
REQ-018 SHALL not bypass while full: a push and a pop in the same cycle are not possible when level==DEPTH.
REQ-019 SHALL pop on a cycle with out_valid && out_ready; out_data/out_last are taken combinationally from the entry at the read pointer.
REQ-020 SHALL present a flit pushed at edge N on the outputs after edge N (one-cycle latency, no same-cycle input-to-output path).
REQ-021 SHALL, when FULLPACKET=0, drive out_valid = (level != 0).
REQ-022 SHALL, when FULLPACKET=1, drive out_valid = (level != 0) && ((packet_count != 0) || (level == DEPTH)); the level==DEPTH term is a deadlock escape that streams an oversize packet out.
REQ-023 SHALL update level as +1 on push only, -1 on pop only, and leave it unchanged on a simultaneous push and pop.
REQ-024 SHALL update packet_count as +1 on push with in_last=1, -1 on pop with out_last=1, and leave it unchanged when both occur in the same cycle.
REQ-025 SHALL hold out_data/out_last stable while out_valid && !out_ready, since the read pointer changes only on pop.
REQ-026 SHALL not corrupt stored entries, pointers or counters when in_valid=1 with in_ready=0; the flit is simply not accepted.
REQ-027 SHALL keep the outputs undefined-safe when level==0 (out_valid=0); out_data content then does not matter.

Reset
REQ-028 SHALL, when rst=1 at an edge, clear the read pointer, write pointer, level and packet_count to 0; array contents are not reset.
REQ-029 SHALL, after reset, present in_ready=1, out_valid=0, level=0 and packet_count=0 from the cycle following the reset edge.
REQ-030 SHALL, on reset asserted mid-packet or mid-transfer, discard all stored flits, with no partial packet surviving.
REQ-031 SHALL give rst priority over a push or pop in the same cycle.

Verification
REQ-032 SHALL cover: FULLPACKET=0, push 0x1111 (last=0) then 0x2222 (last=1) with out_ready=1 -> out_valid rises one cycle after each push, data in order, packet_count returns to 0.
REQ-033 SHALL cover: FULLPACKET=1, push 3 flits with last only on the third -> out_valid=0 until the cycle after the third push, then 3 flits popped back-to-back.
REQ-034 SHALL cover: DEPTH=8, out_ready=0, push 9 flits -> in_ready=0 after the 8th, level=8, the 9th not accepted; one pop restores in_ready.
REQ-035 SHALL cover: simultaneous push and pop at level=4 across the pointer wrap (write at 7->0) -> level stays 4 and data order is preserved.
REQ-036 SHALL cover: FULLPACKET=1, DEPTH=4, a 6-flit packet -> out_valid asserts at level=4, and all 6 flits emerge in order.
REQ-037 SHALL cover: rst pulsed with level=5 and packet_count=2 -> next cycle level=0, packet_count=0, out_valid=0, in_ready=1.
